// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among N requesters.
// Optional build macro MUL_SHARE_STATS_EN adds issue/stall counters.
module mul_share_arbiter #(
    parameter int N       = 4,
    parameter int A_W     = 49,
    parameter int B_W     = 44,
    parameter int P_W     = 93,
    parameter int MUL_LAT = 4,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*A_W-1:0]  req_a,
    input  logic [N*B_W-1:0]  req_b,
    output logic              mul_ce,
    output logic [A_W-1:0]    mul_din0,
    output logic [B_W-1:0]    mul_din1,
    input  logic [P_W-1:0]    mul_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
`ifdef MUL_SHARE_STATS_EN
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stall,
`endif
    output logic [P_W-1:0]    out_data
);

    logic [MUL_LAT-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [MUL_LAT];
    logic [ID_W-1:0]    rr_ptr;
    logic               advance;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic               issue;

    // The whole pipe freezes only when the head result is held by the consumer.
    assign advance = ~(tag_v[MUL_LAT-1] & ~out_ready);
    assign mul_ce  = advance & ~reset;
    assign issue   = advance & ~reset & grant_found;

    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            mul_din0 = req_a[int'(grant_id)*A_W +: A_W];
            mul_din1 = req_b[int'(grant_id)*B_W +: B_W];
        end
    end

    // Tag pipe stages track the multiplier's internal registers one-for-one.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v  <= '0;
            rr_ptr <= ID_W'(N - 1);
            for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
        end else if (advance) begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant_id;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (issue) rr_ptr <= grant_id;
        end
    end

    assign out_valid = tag_v[MUL_LAT-1];
    assign out_id    = tag_id[MUL_LAT-1];
    assign out_data  = mul_dout;

`ifdef MUL_SHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue) stat_issued <= stat_issued + 32'd1;
            if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a behavioural shared multiplier.
// Build with MUL_SHARE_STATS_EN defined to also exercise the counters.
module tb_mul_share_arbiter;
    localparam int N = 4, A_W = 49, B_W = 44, P_W = 93, L = 4, ID_W = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*A_W-1:0]  req_a;
    logic [N*B_W-1:0]  req_b;
    logic              mul_ce;
    logic [A_W-1:0]    mul_din0;
    logic [B_W-1:0]    mul_din1;
    logic [P_W-1:0]    mul_dout;
    logic              out_valid;
    logic              out_ready;
    logic [ID_W-1:0]   out_id;
    logic [P_W-1:0]    out_data;
`ifdef MUL_SHARE_STATS_EN
    logic [31:0]       stat_issued;
    logic [31:0]       stat_stall;
`endif

    mul_share_arbiter #(.N(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(L), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0),
        .mul_din1(mul_din1), .mul_dout(mul_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id),
`ifdef MUL_SHARE_STATS_EN
        .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
        .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: product registered on capture, L-1 further stages, all gated by ce.
    logic signed [P_W-1:0] mpipe [L];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= $signed({1'b0, mul_din0}) * $signed(mul_din1);
            for (int s = 1; s < L; s++) mpipe[s] <= mpipe[s-1];
        end
    end
    assign mul_dout = mpipe[L-1];

    typedef struct {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  data;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int id, input logic signed [P_W-1:0] d);
        exp_t e;
        e.id = ID_W'(id);
        e.data = d;
        q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        req_a[i*A_W +: A_W] = a;
        req_b[i*B_W +: B_W] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_mul_ce", mul_ce, 0);
        step();
        reset = 1'b0;
        req_valid = '0;
        q.delete();
    endtask

    task automatic wait_drain();
        int g = 0;
        while (q.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", q.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    // Monitor: scoreboard pops on every handshake plus stall/one-hot invariants.
    logic             prev_stall = 1'b0;
    logic [P_W-1:0]   prev_data;
    logic [ID_W-1:0]  prev_id;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ready_onehot", ($countones(req_ready) <= 1), 1);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_result_id", {1'b1, out_id}, 0);
                    end else begin
                        e = q.pop_front();
                        check("result_id", out_id, e.id);
                        check("result_data", out_data, e.data);
                    end
                end
                if (out_valid && !out_ready) begin
                    check("stall_mul_ce", mul_ce, 0);
                    check("stall_req_ready", req_ready, 0);
                    if (prev_stall) begin
                        check("stall_data_stable", out_data, prev_data);
                        check("stall_id_stable", out_id, prev_id);
                    end
                    prev_stall = 1'b1;
                    prev_data = out_data;
                    prev_id = out_id;
                end else begin
                    prev_stall = 1'b0;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic signed [P_W-1:0] rr_exp [4] = '{-93'sd10, -93'sd22, -93'sd36, -93'sd52};
    logic signed [P_W-1:0] bp_exp [8] = '{-93'sd4, -93'sd6, -93'sd6, -93'sd4, 93'sd0, 93'sd6, 93'sd14, 93'sd24};
    logic signed [P_W-1:0] bub_exp [4] = '{93'sd14, 93'sd21, 93'sd28, 93'sd35};

    initial begin
        int n;
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        out_ready = 1'b1;
        do_reset();

        // Single request: latency and sign extension.
        step();
        set_op(0, 3, -5);
        req_valid = 4'b0001;
        push_exp(0, -93'sd15);
        @(negedge clk);
        check("single_grant", req_ready, 4'b0001);
        n = 0;
        do begin
            step();
            req_valid = '0;
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("single_latency", n, 4);
        wait_drain();

        // Full-range operands: max unsigned A times most negative B.
        step();
        set_op(3, 49'h1_FFFF_FFFF_FFFF, 44'h800_0000_0000);
        req_valid = 4'b1000;
        push_exp(3, {1'b1, 92'b0} + (93'd1 << 43));
        @(negedge clk);
        check("boundary_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        wait_drain();

        // Round robin with all requesters valid.
        do_reset();
        step();
        for (int i = 0; i < 4; i++) set_op(i, 10 + i, -(i + 1));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push_exp(k % 4, rr_exp[k % 4]);
            @(negedge clk);
            check("rr_grant", req_ready, 4'b0001 << (k % 4));
            step();
        end
        req_valid = '0;
        wait_drain();

        // Backpressure mid-stream from requester 2.
        step();
        fork
            begin
                int k = 0;
                int guard = 0;
                set_op(2, 1, -4);
                req_valid = 4'b0100;
                while (k < 8 && guard < 100) begin
                    @(negedge clk);
                    if (req_ready[2]) begin
                        push_exp(2, bp_exp[k]);
                        k++;
                    end
                    step();
                    guard++;
                    if (k < 8) set_op(2, k + 1, k - 4);
                    else req_valid = '0;
                end
                req_valid = '0;
                check("bp_all_accepted", k, 8);
            end
            begin
                repeat (6) step();
                out_ready = 1'b0;
                repeat (5) step();
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Bubbles: requester 1 on alternate cycles.
        step();
        for (int j = 0; j < 4; j++) begin
            set_op(1, j + 2, 7);
            req_valid = 4'b0010;
            push_exp(1, bub_exp[j]);
            @(negedge clk);
            check("bubble_grant", req_ready, 4'b0010);
            step();
            req_valid = '0;
            @(negedge clk);
            check("bubble_idle", req_ready, 0);
            step();
        end
        wait_drain();

        // Reset with three operations in flight.
        step();
        set_op(1, 5, 5);
        req_valid = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("inflight_grant", req_ready, 4'b0010);
            step();
        end
        reset = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        set_op(0, 9, -9);
        set_op(2, 4, 4);
        req_valid = 4'b0101;
        @(negedge clk);
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_grant", req_ready, 4'b0001);
        push_exp(0, -93'sd81);
        step();
        req_valid = '0;
        wait_drain();

`ifdef MUL_SHARE_STATS_EN
        do_reset();
        step();
        set_op(0, 1, 1);
        req_valid = 4'b0001;
        for (int j = 0; j < 10; j++) begin
            push_exp(0, 93'sd1);
            @(negedge clk);
            check("stats_grant", req_ready, 4'b0001);
            step();
        end
        req_valid = '0;
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        wait_drain();
        check("stat_issued", stat_issued, 10);
        check("stat_stall", stat_stall, 3);
        do_reset();
        @(negedge clk);
        check("stat_issued_reset", stat_issued, 0);
        check("stat_stall_reset", stat_stall, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
